// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks the operands MSB slice first and stops on the
// first differing slice. Signed operands are mapped to offset-binary so one unsigned path serves both.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             y0,
  output logic             y1,
  output logic             y2
);

  localparam int S  = WIDTH / DIGIT;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_magnitude_comparator: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             y0_q, y0_d;
  logic             y1_q, y1_d;
  logic             y2_q, y2_d;

  // The captured operands shift left each step, so the current slice is always the top DIGIT bits.
  logic [DIGIT-1:0] slice_a, slice_b;
  assign slice_a = a_q[WIDTH-1 -: DIGIT];
  assign slice_b = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
          b_d     = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
          idx_d   = '0;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (slice_a != slice_b) begin
          y0_d    = 1'b0;
          y1_d    = (slice_a < slice_b);
          y2_d    = (slice_a > slice_b);
          state_d = DONE;
        end else if (idx_q == IW'(S - 1)) begin
          y0_d    = 1'b1;
          y1_d    = 1'b0;
          y2_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      y0_q    <= 1'b0;
      y1_q    <= 1'b0;
      y2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  // Status outputs decode directly from the state flops, so they clear with the async reset.
  assign busy = (state_q == CMP);
  assign done = (state_q == DONE);
  assign y0   = y0_q;
  assign y1   = y1_q;
  assign y2   = y2_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: 8-bit/2-bit default instance plus a
// 16-bit/4-bit instance checked against a reference signed/unsigned compare.
module tb_serial_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, y0_8, y1_8, y2_8;
  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16, y0_16, y1_16, y2_16;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y0(y0_8), .y1(y1_8), .y2(y2_8)
  );

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .y0(y0_16), .y1(y1_16), .y2(y2_16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done on the 8-bit instance; returns edges counted since E0.
  task automatic wait_done8(output int lat);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic smv, input logic [2:0] exp_flags, input int exp_lat,
                      input bit hold_start);
    int lat;
    @(negedge clk);
    a8 = av; b8 = bv; sm8 = smv; start8 = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, busy8, 1'b1);
    if (!hold_start) start8 = 1'b0;
    // Operand changes during CMP must not matter.
    a8 = ~av; b8 = av; sm8 = ~smv;
    wait_done8(lat);
    start8 = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_flags"}, {y2_8, y1_8, y0_8}, exp_flags);
    check({tag, "_busy_done"}, busy8, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, {busy8, done8}, 2'b00);
    check({tag, "_hold"}, {y2_8, y1_8, y0_8}, exp_flags);
  endtask

  initial begin
    int lat;
    int nexp;
    logic [15:0] ra, rb, dx;
    logic        rsm;
    logic [2:0]  eflags;

    rst_n = 1'b0; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy8, done8, y2_8, y1_8, y0_8}, 5'b0);
    @(negedge clk); rst_n = 1'b1;

    // Flags are {y2,y1,y0} = {gt,lt,eq}.
    run8("early_exit", 8'hA5, 8'h25, 1'b0, 3'b100, 1, 1'b0);

    // Reset mid-operation, observed before any further clock edge.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h3D; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_busy", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {busy8, done8, y2_8, y1_8, y0_8}, 5'b0);
    @(negedge clk); rst_n = 1'b1;
    run8("after_reset", 8'h3C, 8'h3D, 1'b0, 3'b010, 4, 1'b0);

    run8("equal", 8'h5A, 8'h5A, 1'b0, 3'b001, 4, 1'b0);
    run8("signed_80_7F", 8'h80, 8'h7F, 1'b1, 3'b010, 1, 1'b0);
    run8("unsigned_80_7F", 8'h80, 8'h7F, 1'b0, 3'b100, 1, 1'b0);
    run8("signed_FF_FE", 8'hFF, 8'hFE, 1'b1, 3'b100, 4, 1'b0);
    run8("start_held", 8'h12, 8'h13, 1'b0, 3'b010, 4, 1'b1);

    // Back-to-back: new start issued during the DONE cycle.
    @(negedge clk);
    a8 = 8'hC0; b8 = 8'h40; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat);
    check("b2b_first_lat", lat, 1);
    check("b2b_first_flags", {y2_8, y1_8, y0_8}, 3'b100);
    a8 = 8'h40; b8 = 8'h41; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_no_idle", {busy8, done8}, 2'b10);
    check("b2b_flags_hold", {y2_8, y1_8, y0_8}, 3'b100);
    wait_done8(lat);
    check("b2b_second_lat", lat, 4);
    check("b2b_second_flags", {y2_8, y1_8, y0_8}, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    check("flags_idle_hold", {busy8, done8, y2_8, y1_8, y0_8}, 5'b00010);

    // WIDTH=16, DIGIT=4 against a reference compare.
    for (int t = 0; t < 24; t++) begin
      ra  = 16'($urandom);
      rsm = t[0];
      case (t % 4)
        0:       rb = ra;
        1:       rb = 16'($urandom);
        default: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      endcase
      if (t == 2) begin ra = 16'h8000; rb = 16'h7FFF; end
      dx   = ra ^ rb;
      nexp = 4;
      for (int i = 0; i < 4; i++) begin
        if (((dx >> (12 - 4 * i)) & 16'h000F) != 16'h0) begin
          nexp = i + 1;
          break;
        end
      end
      if (rsm) eflags = {$signed(ra) > $signed(rb), $signed(ra) < $signed(rb), ra == rb};
      else     eflags = {ra > rb, ra < rb, ra == rb};
      @(negedge clk);
      a16 = ra; b16 = rb; sm16 = rsm; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w16_lat_%0d", t), lat, nexp);
      check($sformatf("w16_flags_%0d", t), {y2_16, y1_16, y0_16}, eflags);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised magnitude comparator that resolves equal, less-than and greater-than for WIDTH-bit operands. It examines DIGIT bits per clock, most significant slice first, and terminates early on the first differing slice. Signed and unsigned modes are selectable per comparison. A start/busy/done handshake and registered result flags let it sit on a control datapath where a single-cycle wide comparator would limit timing.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle. WIDTH % DIGIT != 0 is an elaboration error.
- S (localparam) = WIDTH/DIGIT: number of slices.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a comparison; sampled only while busy=0.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; result flags updated this cycle.
- y0  out  1  A == B (registered).
- y1  out  1  A < B (registered).
- y2  out  1  A > B (registered).

## Operation
- **States:**
  - IDLE (busy=0, done=0).
  - CMP (busy=1, done=0).
  - DONE (busy=0, done=1, lasts one cycle).
- **IDLE:** start=1 at an edge captures a, b and signed_mode into internal registers, clears the slice index to 0, and moves to CMP.
- **Signed handling:** when signed_mode=1, the captured MSB of both operands is inverted (offset-binary). The compare is then purely unsigned, so no separate sign path exists.
- **CMP, each edge:** compare slice k, bits [WIDTH-1-k*DIGIT -: DIGIT], of both captured operands.
  - Slices differ: write y1/y2 from the slice compare, clear y0, go to DONE.
  - Slices equal and k == S-1: set y0=1 and y1=y2=0, go to DONE.
  - Otherwise: k increments, remain in CMP.
- **DONE:**
  - start=1 at this edge is accepted exactly as in IDLE and goes to CMP, allowing back-to-back operation.
  - Otherwise the block returns to IDLE.
- **start while busy=1:** ignored. Operand and mode changes during CMP have no effect.
- **Result flags:**
  - Change only on the edge that enters DONE, then hold until the next completion.
  - After the first completion, exactly one of y0/y1/y2 is 1.
- **Reset (asynchronous, any state including mid-CMP):** state=IDLE, busy=0, done=0, y0=y1=y2=0, and internal operand/index registers are cleared. The first start after rst_n rises is accepted normally.

## Timing
- Edge E0 samples start=1; busy=1 from just after E0.
- **Latency:** result is registered at edge E0+n, where n is the 1-based index of the first differing slice, or n=S for equal operands. Range is 1..S cycles.
- At E0+n: busy falls, done rises for exactly one cycle, and y0/y1/y2 are valid and stable from the same edge.
- **Throughput:**
  - Best case, new start asserted in the DONE cycle: one comparison per n+1 edges.
  - With WIDTH=8, DIGIT=2 (S=4): maximum latency is 4 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Defaults WIDTH=8, DIGIT=2 (S=4) unless stated.

- **Reset mid-operation:** start with a=8'h3C, b=8'h3D, then pull rst_n low one cycle later. Required: busy, done, y0, y1 and y2 read 0 immediately, without waiting for a clock edge. The next start then completes normally with y1=1 after 4 cycles.
- **Early exit, unsigned:** a=8'hA5, b=8'h25, signed_mode=0. Required: done at E0+1, y2=1, y0=y1=0.
- **Late difference and equality:**
  - a=8'h3C, b=8'h3D must give done at E0+4 with y1=1.
  - a=b=8'h5A must give done at E0+4 with y0=1.
- **Sign mode:** a=8'h80, b=8'h7F.
  - signed_mode=1 must give y1=1 at E0+1.
  - signed_mode=0 must give y2=1 at E0+1.
  - a=8'hFF, b=8'hFE with signed_mode=1 (−1 vs −2) must give y2=1 at E0+4.
- **Handshake:**
  - start held high during CMP must not restart: done appears once, at the expected edge.
  - start asserted in the DONE cycle with new operands must be accepted; the second result follows with no IDLE cycle in between.
  - Flags must hold their values between completions.
- **Parameter sweep:**
  - WIDTH=16, DIGIT=4: random operands in both modes checked against a reference signed/unsigned compare, with latency equal to the first-differing-slice index.
  - WIDTH=6, DIGIT=4 must fail elaboration.
